data_mem_responder: RTL and testbench

//  On-chip data memory that answers LSU read/write requests over the valid/ready handshake.

---
 rtl/data_mem_responder_if.sv | 30 +++
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: LSU <-> data memory request/response bundle.
// All per-port fields are packed with port p at [p*WIDTH +: WIDTH].
interface data_mem_responder_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic [NUM_PORTS-1:0]           mem_read_valid;
    logic [NUM_PORTS*ADDR_BITS-1:0] mem_read_address;
    logic [NUM_PORTS-1:0]           mem_read_ready;
    logic [NUM_PORTS*DATA_BITS-1:0] mem_read_data;
    logic [NUM_PORTS-1:0]           mem_write_valid;
    logic [NUM_PORTS*ADDR_BITS-1:0] mem_write_address;
    logic [NUM_PORTS*DATA_BITS-1:0] mem_write_data;
    logic [NUM_PORTS-1:0]           mem_write_ready;

    // LSU side: issues requests, receives responses.
    modport master (
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    // Memory side: accepts requests, returns responses.
    modport slave (
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: round-robin multi-port on-chip data memory with a
// fixed READ_LATENCY response delay (reads and writes alike).
// Optional MEM_STATS_EN macro adds saturating read/write/stall counters.
module data_mem_responder #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]           stat_reads,
    output logic [15:0]           stat_writes,
    output logic [15:0]           stat_stalls
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    localparam int unsigned NP       = NUM_PORTS;
    localparam int          RR_BITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int          CNT_BITS = $clog2(READ_LATENCY + 1);

    state_t                 state      [NUM_PORTS];
    state_t                 state_next [NUM_PORTS];
    logic [CNT_BITS-1:0]    cnt        [NUM_PORTS];
    logic [CNT_BITS-1:0]    cnt_next   [NUM_PORTS];
    logic                   op_read    [NUM_PORTS];
    logic [DATA_BITS-1:0]   rdata_q    [NUM_PORTS];
    logic [DATA_BITS-1:0]   mem        [2**ADDR_BITS];

    logic [RR_BITS-1:0]     rr;
    logic [RR_BITS-1:0]     idx;
    logic [NUM_PORTS-1:0]   eligible;
    logic                   grant_any;
    logic [RR_BITS-1:0]     grant_idx;
    logic                   grant_read;
    logic [ADDR_BITS-1:0]   grant_raddr;
    logic [ADDR_BITS-1:0]   grant_waddr;
    logic [DATA_BITS-1:0]   grant_wdata;

    // Eligibility and round-robin pick of the first eligible port at or after rr.
    always_comb begin
        eligible  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            eligible[p] = (state[p] == IDLE) &&
                          (bus.mem_read_valid[p] || bus.mem_write_valid[p]);
        end
        for (int unsigned off = 0; off < NP; off++) begin
            idx = RR_BITS'((32'(rr) + off) % NP);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Operation and operands of the granted port; read wins when both valids are set.
    always_comb begin
        grant_read  = bus.mem_read_valid[grant_idx];
        grant_raddr = bus.mem_read_address[grant_idx*ADDR_BITS +: ADDR_BITS];
        grant_waddr = bus.mem_write_address[grant_idx*ADDR_BITS +: ADDR_BITS];
        grant_wdata = bus.mem_write_data[grant_idx*DATA_BITS +: DATA_BITS];
    end

    // Per-port next state: IDLE -> WAIT -> RESPOND -> IDLE.
    always_comb begin
        for (int unsigned p = 0; p < NP; p++) begin
            state_next[p] = state[p];
            cnt_next[p]   = cnt[p];
            case (state[p])
                IDLE: begin
                    if (grant_any && (grant_idx == RR_BITS'(p))) begin
                        if (READ_LATENCY == 1) begin
                            state_next[p] = RESPOND;
                        end else begin
                            state_next[p] = WAIT;
                            cnt_next[p]   = CNT_BITS'(READ_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt_next[p] = cnt[p] - 1'b1;
                    if (cnt[p] == CNT_BITS'(1)) state_next[p] = RESPOND;
                end
                RESPOND: begin
                    if (!(op_read[p] ? bus.mem_read_valid[p] : bus.mem_write_valid[p]))
                        state_next[p] = IDLE;
                end
                default: state_next[p] = IDLE;
            endcase
        end
    end

    // State, counters, latched op, read data register and rr pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned p = 0; p < NP; p++) begin
                state[p]   <= IDLE;
                cnt[p]     <= '0;
                op_read[p] <= 1'b0;
                rdata_q[p] <= '0;
            end
            rr <= '0;
        end else begin
            for (int unsigned p = 0; p < NP; p++) begin
                state[p] <= state_next[p];
                cnt[p]   <= cnt_next[p];
            end
            if (grant_any) begin
                op_read[grant_idx] <= grant_read;
                if (grant_read) rdata_q[grant_idx] <= mem[grant_raddr];
                rr <= (32'(grant_idx) == NP - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Memory array write on the grant edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && grant_any && !grant_read) mem[grant_waddr] <= grant_wdata;
    end

    // Ready is decoded from the registered state, so it still changes only on clock edges.
    always_comb begin
        bus.mem_read_ready  = '0;
        bus.mem_write_ready = '0;
        bus.mem_read_data   = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            bus.mem_read_ready[p]  = (state[p] == RESPOND) &&  op_read[p];
            bus.mem_write_ready[p] = (state[p] == RESPOND) && !op_read[p];
            bus.mem_read_data[p*DATA_BITS +: DATA_BITS] = rdata_q[p];
        end
    end

`ifdef MEM_STATS_EN
    logic stall;

    // A stall cycle has more eligible ports than the single grant can serve.
    always_comb begin
        stall = ($countones(eligible) > 1);
    end

    // Saturating access/stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stalls <= '0;
        end else begin
            if (grant_any && grant_read && (stat_reads != '1))
                stat_reads <= stat_reads + 16'd1;
            if (grant_any && !grant_read && (stat_writes != '1))
                stat_writes <= stat_writes + 16'd1;
            if (stall && (stat_stalls != '1))
                stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench with a response scoreboard.
// dut_a runs at READ_LATENCY=2, dut_b at READ_LATENCY=1.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam int NP = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    data_mem_responder_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) bus_a ();
    data_mem_responder_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) bus_b ();

`ifdef MEM_STATS_EN
    logic [15:0] ra, wa, sa, rb, wb, sb;
`endif

    data_mem_responder #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .READ_LATENCY(2)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a)
`ifdef MEM_STATS_EN
        , .stat_reads(ra), .stat_writes(wa), .stat_stalls(sa)
`endif
    );

    data_mem_responder #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .READ_LATENCY(1)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b)
`ifdef MEM_STATS_EN
        , .stat_reads(rb), .stat_writes(wb), .stat_stalls(sb)
`endif
    );

    typedef struct {
        int         port;
        bit         is_read;
        logic [7:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop one expected response for each rising ready and compare it.
    task automatic mon(input int id, input logic [NP-1:0] rr, input logic [NP-1:0] prr,
                       input logic [NP-1:0] wr, input logic [NP-1:0] pwr,
                       input logic [NP*DB-1:0] rd);
        exp_t e;
        bit   is_rd;
        int   qs;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 2; k++) begin
                is_rd = (k == 0);
                if ((is_rd ? rr[p] : wr[p]) === 1'b1 && (is_rd ? prr[p] : pwr[p]) !== 1'b1) begin
                    qs = (id == 0) ? q_a.size() : q_b.size();
                    chk("sb_response_expected", 32'(qs != 0), 32'd1);
                    if (qs != 0) begin
                        if (id == 0) e = q_a.pop_front();
                        else         e = q_b.pop_front();
                        chk("sb_port", 32'(p), 32'(e.port));
                        chk("sb_op", 32'(is_rd), 32'(e.is_read));
                        if (is_rd) chk("sb_rdata", 32'(rd[p*DB +: DB]), 32'(e.data));
                    end
                end
            end
        end
    endtask

    logic [NP-1:0] prev_rr_a = '0, prev_wr_a = '0, prev_rr_b = '0, prev_wr_b = '0;

    // Response monitor, sampling on the falling edge.
    always @(negedge clk) begin
        mon(0, bus_a.mem_read_ready, prev_rr_a, bus_a.mem_write_ready, prev_wr_a, bus_a.mem_read_data);
        mon(1, bus_b.mem_read_ready, prev_rr_b, bus_b.mem_write_ready, prev_wr_b, bus_b.mem_read_data);
        prev_rr_a = bus_a.mem_read_ready;
        prev_wr_a = bus_a.mem_write_ready;
        prev_rr_b = bus_b.mem_read_ready;
        prev_wr_b = bus_b.mem_write_ready;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv_rd(input int id, input int p, input logic v, input logic [7:0] a);
        if (id == 0) begin
            bus_a.mem_read_valid[p] = v;
            bus_a.mem_read_address[p*AB +: AB] = a;
        end else begin
            bus_b.mem_read_valid[p] = v;
            bus_b.mem_read_address[p*AB +: AB] = a;
        end
    endtask

    task automatic drv_wr(input int id, input int p, input logic v, input logic [7:0] a,
                          input logic [7:0] d);
        if (id == 0) begin
            bus_a.mem_write_valid[p] = v;
            bus_a.mem_write_address[p*AB +: AB] = a;
            bus_a.mem_write_data[p*DB +: DB] = d;
        end else begin
            bus_b.mem_write_valid[p] = v;
            bus_b.mem_write_address[p*AB +: AB] = a;
            bus_b.mem_write_data[p*DB +: DB] = d;
        end
    endtask

    function automatic logic ready_of(input int id, input int p, input bit is_read);
        if (id == 0) return is_read ? bus_a.mem_read_ready[p] : bus_a.mem_write_ready[p];
        return is_read ? bus_b.mem_read_ready[p] : bus_b.mem_write_ready[p];
    endfunction

    // Wait (bounded) for a ready and check the number of edges it took.
    task automatic wait_ready(input int id, input int p, input bit is_read, input int exp_n,
                              input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            step(1);
            n++;
            seen = (ready_of(id, p, is_read) === 1'b1);
        end
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.mem_read_valid = '0;   bus_a.mem_read_address = '0;
        bus_a.mem_write_valid = '0;  bus_a.mem_write_address = '0; bus_a.mem_write_data = '0;
        bus_b.mem_read_valid = '0;   bus_b.mem_read_address = '0;
        bus_b.mem_write_valid = '0;  bus_b.mem_write_address = '0; bus_b.mem_write_data = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(2);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        chk("rst_rd_ready", 32'(bus_a.mem_read_ready), 32'h0);
        chk("rst_wr_ready", 32'(bus_a.mem_write_ready), 32'h0);
        chk("rst_rd_data", 32'(bus_a.mem_read_data), 32'h0);

        // 1: L=2 write then read-back on port0
        q_a.push_back('{0, 1'b0, 8'h00});
        drv_wr(0, 0, 1'b1, 8'h10, 8'hA5);
        step(1);
        chk("t1_no_ready_on_grant", 32'(bus_a.mem_write_ready), 32'h0);
        step(1);
        chk("t1_wr_ready", 32'(bus_a.mem_write_ready), 32'h1);
        drv_wr(0, 0, 1'b0, 8'h10, 8'hA5);
        step(1);
        chk("t1_wr_ready_clear", 32'(bus_a.mem_write_ready), 32'h0);
        q_a.push_back('{0, 1'b1, 8'hA5});
        drv_rd(0, 0, 1'b1, 8'h10);
        wait_ready(0, 0, 1'b1, 2, "t1_rd_latency");
        chk("t1_rd_data", 32'(bus_a.mem_read_data[7:0]), 32'hA5);
        chk("t1_wr_ready_indep", 32'(bus_a.mem_write_ready), 32'h0);
        drv_rd(0, 0, 1'b0, 8'h10);
        step(1);
        chk("t1_rd_ready_clear", 32'(bus_a.mem_read_ready), 32'h0);

        // 3: port1 holds valid 3 cycles past ready
        q_a.push_back('{1, 1'b1, 8'hA5});
        drv_rd(0, 1, 1'b1, 8'h10);
        wait_ready(0, 1, 1'b1, 2, "t3_latency");
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t3_ready_held", 32'(bus_a.mem_read_ready[1]), 32'h1);
            chk("t3_data_stable", 32'(bus_a.mem_read_data[15:8]), 32'hA5);
        end
        drv_rd(0, 1, 1'b0, 8'h10);
        step(1);
        chk("t3_ready_clear", 32'(bus_a.mem_read_ready[1]), 32'h0);

        // 4: port2 writes addr 5 ahead of port3's read of addr 5
        q_a.push_back('{2, 1'b0, 8'h00});
        q_a.push_back('{3, 1'b1, 8'h33});
        drv_wr(0, 2, 1'b1, 8'h05, 8'h33);
        drv_rd(0, 3, 1'b1, 8'h05);
        wait_ready(0, 3, 1'b1, 3, "t4_rd_latency");
        chk("t4_rd_data", 32'(bus_a.mem_read_data[31:24]), 32'h33);
        chk("t4_wr_ready", 32'(bus_a.mem_write_ready), 32'h4);
        drv_wr(0, 2, 1'b0, 8'h05, 8'h33);
        drv_rd(0, 3, 1'b0, 8'h05);
        step(1);
        chk("t4_rd_clear", 32'(bus_a.mem_read_ready), 32'h0);
        chk("t4_wr_clear", 32'(bus_a.mem_write_ready), 32'h0);

        // 5: reset while port0 waits
        drv_rd(0, 0, 1'b1, 8'h10);
        step(1);
        chk("t5_in_wait", 32'(bus_a.mem_read_ready), 32'h0);
        rst_a = 1'b1;
        drv_rd(0, 0, 1'b0, 8'h10);
        step(1);
        chk("t5_rst_rd_ready", 32'(bus_a.mem_read_ready), 32'h0);
        chk("t5_rst_wr_ready", 32'(bus_a.mem_write_ready), 32'h0);
        chk("t5_rst_rd_data", 32'(bus_a.mem_read_data), 32'h0);
        rst_a = 1'b0;
        step(1);
        chk("t5_aborted", 32'(bus_a.mem_read_ready), 32'h0);
        q_a.push_back('{0, 1'b1, 8'hA5});
        q_a.push_back('{1, 1'b1, 8'h33});
        drv_rd(0, 0, 1'b1, 8'h10);
        drv_rd(0, 1, 1'b1, 8'h05);
        wait_ready(0, 0, 1'b1, 2, "t5_rr_port0_first");
        chk("t5_only_port0", 32'(bus_a.mem_read_ready), 32'h1);
        wait_ready(0, 1, 1'b1, 1, "t5_port1_next");
        chk("t5_port1_data", 32'(bus_a.mem_read_data[15:8]), 32'h33);
        drv_rd(0, 0, 1'b0, 8'h10);
        drv_rd(0, 1, 1'b0, 8'h05);
        step(1);

        // 2: L=1 fill then four simultaneous reads
        for (int p = 0; p < NP; p++) begin
            q_b.push_back('{p, 1'b0, 8'h00});
            drv_wr(1, p, 1'b1, 8'(8'h20 + p), 8'(8'h50 + p));
        end
        wait_ready(1, 3, 1'b0, 4, "t2_wr_all");
        for (int p = 0; p < NP; p++) drv_wr(1, p, 1'b0, 8'h00, 8'h00);
        step(1);
        rst_b = 1'b1;
        step(1);
        rst_b = 1'b0;
        for (int p = 0; p < NP; p++) begin
            q_b.push_back('{p, 1'b1, 8'(8'h50 + p)});
            drv_rd(1, p, 1'b1, 8'(8'h20 + p));
        end
        for (int k = 1; k <= NP; k++) begin
            step(1);
            chk("t2_grant_order", 32'(bus_b.mem_read_ready), 32'((1 << k) - 1));
        end
        chk("t2_rd_data", 32'(bus_b.mem_read_data), 32'h53525150);
        for (int p = 0; p < NP; p++) drv_rd(1, p, 1'b0, 8'h00);
        step(1);
        chk("t2_ready_clear", 32'(bus_b.mem_read_ready), 32'h0);

`ifdef MEM_STATS_EN
        // 6: statistics after four simultaneous reads
        chk("t6_stat_reads", 32'(rb), 32'd4);
        chk("t6_stat_writes", 32'(wb), 32'd0);
        chk("t6_stat_stalls", 32'(sb), 32'd3);
`endif

        step(2);
        chk("sb_a_drained", 32'(q_a.size()), 32'd0);
        chk("sb_b_drained", 32'(q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
